// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
//   Generates a triangular "breathing" duty profile for a 100-step PWM block.
//   The profile ramps up, holds high, ramps down, and holds low. It can run
//   once or loop until stopped. The configuration is captured when start is
//   accepted in IDLE.
//
// Ports:
//   clk          system clock
//   sys_rst_n    asynchronous, active-low reset
//   start        one-cycle request to begin a profile (IDLE only)
//   stop         abort to IDLE; has priority over start
//   continuous   1: loop until stop, 0: single profile then done
//   duty_min     low duty limit (clamped to 1..100)
//   duty_max     high duty limit (clamped to 1..100)
//   step_period  clk cycles per duty step (0 acts as 1)
//   hold_steps   step ticks spent in each hold phase (0 acts as 1)
//   duty_cycle   registered duty for the PWM block (0 while IDLE)
//   busy         high in any state except IDLE
//   done         one-cycle pulse when a single profile completes
//   phase        state code: IDLE=0 RAMP_UP=1 HOLD_HIGH=2 RAMP_DOWN=3 HOLD_LOW=4
module pwm_fade_sequencer #(
  parameter int STEP_W = 16,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [6:0]        duty_min,
  input  logic [6:0]        duty_max,
  input  logic [STEP_W-1:0] step_period,
  input  logic [HOLD_W-1:0] hold_steps,
  output logic [6:0]        duty_cycle,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  state_t            state_reg;
  logic [6:0]        duty_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [STEP_W-1:0] timer_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [6:0]        min_eff_reg;
  logic [6:0]        max_eff_reg;
  logic [STEP_W-1:0] step_eff_reg;
  logic [HOLD_W-1:0] hold_eff_reg;
  logic              cont_reg;

  // Values captured on an accepted start.
  logic [6:0]        min_clamp;
  logic [6:0]        max_clamp;
  logic [6:0]        min_cap;
  logic [STEP_W-1:0] step_cap;
  logic [HOLD_W-1:0] hold_cap;

  always_comb begin
    min_clamp = duty_min;
    if (duty_min < 7'd1)   min_clamp = 7'd1;
    if (duty_min > 7'd100) min_clamp = 7'd100;
    max_clamp = duty_max;
    if (duty_max < 7'd1)   max_clamp = 7'd1;
    if (duty_max > 7'd100) max_clamp = 7'd100;
    // Inverted limits collapse to a flat profile at the high limit.
    min_cap  = (min_clamp > max_clamp) ? max_clamp : min_clamp;
    step_cap = (step_period == '0) ? STEP_W'(1) : step_period;
    hold_cap = (hold_steps == '0) ? HOLD_W'(1) : hold_steps;
  end

  logic       tick;
  logic       hold_last;
  logic [6:0] duty_inc;
  logic [6:0] duty_dec;

  assign tick      = (timer_reg == step_eff_reg - STEP_W'(1));
  assign hold_last = (hold_cnt_reg == hold_eff_reg - HOLD_W'(1));
  assign duty_inc  = duty_reg + 7'd1;
  assign duty_dec  = duty_reg - 7'd1;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      duty_reg     <= 7'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      timer_reg    <= '0;
      hold_cnt_reg <= '0;
      min_eff_reg  <= 7'd1;
      max_eff_reg  <= 7'd1;
      step_eff_reg <= STEP_W'(1);
      hold_eff_reg <= HOLD_W'(1);
      cont_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (start && !stop) begin
          min_eff_reg  <= min_cap;
          max_eff_reg  <= max_clamp;
          step_eff_reg <= step_cap;
          hold_eff_reg <= hold_cap;
          cont_reg     <= continuous;
          state_reg    <= RAMP_UP;
          duty_reg     <= min_cap;
          busy_reg     <= 1'b1;
          timer_reg    <= '0;
          hold_cnt_reg <= '0;
        end
      end else if (stop) begin
        state_reg    <= IDLE;
        duty_reg     <= 7'd0;
        busy_reg     <= 1'b0;
        timer_reg    <= '0;
        hold_cnt_reg <= '0;
      end else begin
        // Transitions only happen on a tick, where the timer wraps to 0
        // anyway, so every state starts with a full step interval.
        timer_reg <= tick ? '0 : timer_reg + STEP_W'(1);
        if (tick) begin
          case (state_reg)
            RAMP_UP: begin
              if (duty_reg < max_eff_reg) duty_reg <= duty_inc;
              if (duty_reg >= max_eff_reg || duty_inc == max_eff_reg) begin
                state_reg    <= HOLD_HIGH;
                hold_cnt_reg <= '0;
              end
            end
            HOLD_HIGH: begin
              if (hold_last) begin
                state_reg    <= RAMP_DOWN;
                hold_cnt_reg <= '0;
              end else begin
                hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
              end
            end
            RAMP_DOWN: begin
              if (duty_reg > min_eff_reg) duty_reg <= duty_dec;
              if (duty_reg <= min_eff_reg || duty_dec == min_eff_reg) begin
                state_reg    <= HOLD_LOW;
                hold_cnt_reg <= '0;
              end
            end
            HOLD_LOW: begin
              if (hold_last) begin
                hold_cnt_reg <= '0;
                if (cont_reg) begin
                  state_reg <= RAMP_UP;
                end else begin
                  state_reg <= IDLE;
                  duty_reg  <= 7'd0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                end
              end else begin
                hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
              end
            end
            default: begin
              state_reg <= IDLE;
              duty_reg  <= 7'd0;
              busy_reg  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign duty_cycle = duty_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign phase      = state_reg;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Testbench for pwm_fade_sequencer. A reference model expands each profile
// into a per-cycle list of expected (duty, phase) pairs. The list is built
// directly from the profile rules: ramp intervals, hold lengths, and the step
// period. The bench then compares the DUT against this list on every falling
// edge.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [6:0]  duty_min = 7'd0;
  logic [6:0]  duty_max = 7'd0;
  logic [15:0] step_period = 16'd0;
  logic [7:0]  hold_steps = 8'd0;
  logic [6:0]  duty_cycle;
  logic        busy;
  logic        done;
  logic [2:0]  phase;

  pwm_fade_sequencer #(.STEP_W(16), .HOLD_W(8)) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .duty_min    (duty_min),
    .duty_max    (duty_max),
    .step_period (step_period),
    .hold_steps  (hold_steps),
    .duty_cycle  (duty_cycle),
    .busy        (busy),
    .done        (done),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int d, input int p,
                           input int b, input int dn);
    check({tag, ".duty"},  int'(duty_cycle), d);
    check({tag, ".phase"}, int'(phase), p);
    check({tag, ".busy"},  int'(busy), b);
    check({tag, ".done"},  int'(done), dn);
  endtask

  // One entry per clock cycle of one profile period, beginning with the
  // first RAMP_UP cycle.
  int exp_duty[$];
  int exp_phase[$];

  task automatic build(input int dmin, input int dmax, input int sp, input int hs);
    int mn, mx, st, ho, n;
    mn = (dmin < 1) ? 1 : (dmin > 100) ? 100 : dmin;
    mx = (dmax < 1) ? 1 : (dmax > 100) ? 100 : dmax;
    if (mn > mx) mn = mx;
    st = (sp == 0) ? 1 : sp;
    ho = (hs == 0) ? 1 : hs;
    n  = (mx > mn) ? (mx - mn) : 1;
    exp_duty.delete();
    exp_phase.delete();
    for (int k = 0; k < n; k++)
      for (int c = 0; c < st; c++) begin exp_duty.push_back(mn + k); exp_phase.push_back(1); end
    for (int c = 0; c < ho * st; c++) begin exp_duty.push_back(mx); exp_phase.push_back(2); end
    for (int k = 0; k < n; k++)
      for (int c = 0; c < st; c++) begin exp_duty.push_back(mx - k); exp_phase.push_back(3); end
    for (int c = 0; c < ho * st; c++) begin exp_duty.push_back(mn); exp_phase.push_back(4); end
  endtask

  // abort_at < 0: no stop. Otherwise stop is driven in cycle abort_at,
  // counted from the first RAMP_UP cycle. If abort_start is set, start is
  // driven in the same cycle.
  // noise: random start pulses with new configuration while busy.
  task automatic run_profile(input int dmin, input int dmax, input int sp, input int hs,
                             input bit cont, input int abort_at, input bit abort_start,
                             input bit noise);
    int len;
    int idx;
    int err0;
    err0 = errors;
    build(dmin, dmax, sp, hs);
    len = exp_duty.size();
    @(negedge clk);
    duty_min    = 7'(dmin);
    duty_max    = 7'(dmax);
    step_period = 16'(sp);
    hold_steps  = 8'(hs);
    continuous  = cont;
    stop        = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; cont || i < len; i++) begin
      idx = i % len;
      check_out("run", exp_duty[idx], exp_phase[idx], 1, 0);
      start = 1'b0;
      if (noise && ($urandom_range(0, 5) == 0)) begin
        start       = 1'b1;
        duty_min    = 7'($urandom);
        duty_max    = 7'($urandom);
        step_period = 16'($urandom_range(0, 9));
        hold_steps  = 8'($urandom_range(0, 9));
        continuous  = 1'($urandom);
      end
      if (i == abort_at) begin
        stop  = 1'b1;
        start = abort_start;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        check_out("stop", 0, 0, 0, 0);
        @(negedge clk);
        check_out("after_stop", 0, 0, 0, 0);
        $display("profile min=%0d max=%0d step=%0d hold=%0d cont=%0d aborted at %0d errors=%0d",
                 dmin, dmax, sp, hs, cont, abort_at, errors - err0);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_out("done_cycle", 0, 0, 0, 1);
    @(negedge clk);
    check_out("after_done", 0, 0, 0, 0);
    $display("profile min=%0d max=%0d step=%0d hold=%0d cont=%0d cycles=%0d errors=%0d",
             dmin, dmax, sp, hs, cont, len, errors - err0);
  endtask

  initial begin
    int dmin, dmax;
    // Reset state.
    repeat (3) @(negedge clk);
    check_out("reset", 0, 0, 0, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_out("idle", 0, 0, 0, 0);

    // Asynchronous reset during RAMP_UP.
    duty_min = 7'd10; duty_max = 7'd30; step_period = 16'd4; hold_steps = 8'd2;
    continuous = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst.phase", int'(phase), 1);
    #2 sys_rst_n = 1'b0;
    #1 check_out("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_out("rst_idle", 0, 0, 0, 0);
    end
    $display("reset mid-profile errors=%0d", errors);

    // Worked example, single profile, with noisy start pulses while busy.
    run_profile(10, 13, 4, 2, 1'b0, -1, 1'b0, 1'b1);
    // Continuous operation, stopped at T+50.
    run_profile(10, 13, 4, 2, 1'b1, 50, 1'b0, 1'b0);
    // Clamping and zero step/hold.
    run_profile(0, 120, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    // Inverted limits give a flat profile.
    run_profile(50, 20, 3, 2, 1'b0, -1, 1'b0, 1'b1);
    // Start and stop together in RAMP_DOWN.
    run_profile(10, 13, 4, 2, 1'b0, 26, 1'b1, 1'b0);
    // Flat continuous profile, stopped after several periods.
    run_profile(40, 40, 2, 1, 1'b1, 37, 1'b0, 1'b1);

    // Randomised profiles.
    for (int r = 0; r < 12; r++) begin
      if (r % 2 == 0) begin
        dmin = $urandom_range(0, 110);
        dmax = dmin + $urandom_range(0, 8);
        if (dmax > 127) dmax = 127;
        run_profile(dmin, dmax, $urandom_range(0, 4), $urandom_range(0, 3),
                    1'($urandom), (r % 4 == 0) ? 45 : 90, 1'($urandom), 1'b1);
      end else begin
        run_profile($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'b0, -1, 1'b0, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
